// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the default widths, opcode classes, queue entry layout and fetch states.
package fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8;

    // Opcode classes live in opcode1[7:4]; only OP_HALT matters to fetch.
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDM  = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef struct packed {
        logic [INSTR_W-1:0] op1;
        logic [INSTR_W-1:0] op2;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_queue.sv
// Synchronous prefetch FIFO; a push into a full queue is accepted when a pop
// happens in the same cycle. Flush empties it without touching the storage.
module instr_queue #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_pkg::fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  entry_t                     push_data,
    output entry_t                     head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    import fetch_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the program ROM, fills the prefetch queue and
// hands instructions to decode. Optional halt-opcode stop under FETCH_HALT_EN.
//
//   state  | meaning
//   FETCH  | PC advances by 2 and pushes whenever the queue has room
//   HALTED | halt opcode queued; PC frozen, queue still drains
module instr_fetch #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = fetch_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [7:0]        rom_data1,
    input  logic [7:0]        rom_data2,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        opcode1,
    output logic [7:0]        opcode2,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);
    import fetch_pkg::*;

    typedef struct packed {
        logic [INSTR_W-1:0] op1;
        logic [INSTR_W-1:0] op2;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    fetch_state_t                  state;
    logic [ADDR_W-1:0]             pc;
    entry_t                        push_entry;
    entry_t                        head;
    logic                          q_full;
    logic                          q_empty;
    logic [$clog2(DEPTH+1)-1:0]    count_unused;
    logic                          pop_req;
    logic                          push_req;

    assign instr_valid = !q_empty;
    assign pop_req     = instr_valid && instr_ready;
    assign push_req    = (state == FETCH) && (!q_full || pop_req);
    assign push_entry  = '{op1: rom_data1, op2: rom_data2, pc: pc};

    assign rom_address = pc;
    assign opcode1     = head.op1;
    assign opcode2     = head.op2;
    assign instr_pc    = head.pc;

    // Redirect discards whatever handshake happens in its own cycle.
    instr_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req && !redirect_valid),
        .pop       (pop_req && !redirect_valid),
        .flush     (redirect_valid),
        .push_data (push_entry),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (count_unused)
    );

`ifdef FETCH_HALT_EN
    logic halted_q;
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= '0;
            state <= FETCH;
`ifdef FETCH_HALT_EN
            halted_q <= 1'b0;
`endif
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[ADDR_W-1:1], 1'b0};
            state <= FETCH;
`ifdef FETCH_HALT_EN
            halted_q <= 1'b0;
`endif
        end else if (push_req) begin
            pc <= pc + ADDR_W'(2);
`ifdef FETCH_HALT_EN
            if (rom_data1[7:4] == OP_HALT) begin
                state    <= HALTED;
                halted_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected deliveries, a
// negedge monitor compares every accepted instruction against them.
module tb_instr_fetch;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rom_address;
    logic [7:0]        rom_data1;
    logic [7:0]        rom_data2;
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        opcode1;
    logic [7:0]        opcode2;
    logic [ADDR_W-1:0] instr_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;

    always #5 clk = ~clk;

    instr_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_address    (rom_address),
        .rom_data1      (rom_data1),
        .rom_data2      (rom_data2),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .opcode1        (opcode1),
        .opcode2        (opcode2),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    logic [7:0] rom [256];
    assign rom_data1 = rom[rom_address];
    assign rom_data2 = (rom_address == 8'hFF) ? 8'h00 : rom[rom_address + 8'd1];

    typedef struct packed {
        logic [7:0] op1;
        logic [7:0] op2;
        logic [7:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   strict = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_instr(input logic [7:0] op1, input logic [7:0] op2, input logic [7:0] pc);
        exp_q.push_back('{op1: op1, op2: op2, pc: pc});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        #1;
    endtask

    // Handshakes in a redirect cycle are discarded by the DUT, so skip them.
    always @(negedge clk) begin
        if (strict && !reset && !redirect_valid && instr_valid && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_instr: got op1=%0h op2=%0h pc=%0h, expected none",
                         opcode1, opcode2, instr_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if (opcode1 !== mon_e.op1 || opcode2 !== mon_e.op2 || instr_pc !== mon_e.pc) begin
                    errors++;
                    $display("FAIL instr_delivery: got op1=%0h op2=%0h pc=%0h, expected op1=%0h op2=%0h pc=%0h",
                             opcode1, opcode2, instr_pc, mon_e.op1, mon_e.op2, mon_e.pc);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b      = 8'(i);
            rom[i] = {1'b0, b[6:0]};
        end
        rom[0] = 8'h00; rom[1] = 8'h00;
        rom[2] = 8'h10; rom[3] = 8'hFF;
        rom[4] = 8'h11; rom[5] = 8'h01;
        rom[6] = 8'h12; rom[7] = 8'hF8;
        rom[8] = 8'h80; rom[9] = 8'h13;
        rom[8'h0C] = 8'hF0;

        reset          = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset values and first-fetch latency, then five-instruction stream.
        step(); step();
        @(negedge clk);
        check("rst_rom_address", 32'(rom_address), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_opcode1",     32'(opcode1),     32'd0);
        check("rst_opcode2",     32'(opcode2),     32'd0);
        check("rst_instr_pc",    32'(instr_pc),    32'd0);
        check("rst_halted",      32'(halted),      32'd0);
        expect_instr(8'h00, 8'h00, 8'h00);
        expect_instr(8'h10, 8'hFF, 8'h02);
        expect_instr(8'h11, 8'h01, 8'h04);
        expect_instr(8'h12, 8'hF8, 8'h06);
        expect_instr(8'h80, 8'h13, 8'h08);
        strict = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("valid_before_first_edge", 32'(instr_valid), 32'd0);
        step();
        @(negedge clk);
        check("valid_after_first_edge", 32'(instr_valid), 32'd1);
        drain();
        strict = 1'b0;

        // Backpressure: queue fills, PC holds at 2*DEPTH, nothing lost on release.
        reset       = 1'b1;
        instr_ready = 1'b0;
        step();
        reset = 1'b0;
        repeat (5) step();
        @(negedge clk);
        check("stall_rom_address", 32'(rom_address), 32'(2 * DEPTH));
        check("stall_valid",       32'(instr_valid), 32'd1);
        check("stall_opcode1",     32'(opcode1),     32'h00);
        check("stall_opcode2",     32'(opcode2),     32'h00);
        check("stall_instr_pc",    32'(instr_pc),    32'h00);
        step();
        expect_instr(8'h00, 8'h00, 8'h00);
        expect_instr(8'h10, 8'hFF, 8'h02);
        expect_instr(8'h11, 8'h01, 8'h04);
        expect_instr(8'h12, 8'hF8, 8'h06);
        expect_instr(8'h80, 8'h13, 8'h08);
        strict      = 1'b1;
        instr_ready = 1'b1;
        drain();
        strict = 1'b0;

        // Redirect to an odd target while streaming: one bubble, then 0x0A.
        redirect_valid = 1'b1;
        redirect_pc    = 8'h0B;
        expect_instr(8'h0A, 8'h0B, 8'h0A);
        expect_instr(8'hF0, 8'h0D, 8'h0C);
        strict = 1'b1;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redirect_bubble", 32'(instr_valid), 32'd0);
        step();
        @(negedge clk);
        check("redirect_first_valid", 32'(instr_valid), 32'd1);
        check("redirect_first_pc",    32'(instr_pc),    32'h0A);
        drain();
        strict = 1'b0;

        repeat (4) step();
        @(negedge clk);
`ifdef FETCH_HALT_EN
        check("halt_flag",        32'(halted),      32'd1);
        check("halt_rom_address", 32'(rom_address), 32'h0E);
        check("halt_queue_empty", 32'(instr_valid), 32'd0);
`else
        check("no_halt_flag", 32'(halted), 32'd0);
`endif

        // Redirect to 0 leaves any halt and resumes fetching.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 8'h00;
        expect_instr(8'h00, 8'h00, 8'h00);
        expect_instr(8'h10, 8'hFF, 8'h02);
        strict = 1'b1;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("resume_halted", 32'(halted), 32'd0);
        drain();
        strict = 1'b0;

        // PC wrap from 0xFE to 0x00.
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFC;
        expect_instr(8'h7C, 8'h7D, 8'hFC);
        expect_instr(8'h7E, 8'h7F, 8'hFE);
        expect_instr(8'h00, 8'h00, 8'h00);
        expect_instr(8'h10, 8'hFF, 8'h02);
        strict = 1'b1;
        step();
        redirect_valid = 1'b0;
        drain();
        strict = 1'b0;

        // Reset with a full, stalled queue.
        instr_ready = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("full_before_reset", 32'(instr_valid), 32'd1);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        check("midrst_valid",       32'(instr_valid), 32'd0);
        check("midrst_rom_address", 32'(rom_address), 32'd0);
        check("midrst_instr_pc",    32'(instr_pc),    32'd0);
        check("midrst_halted",      32'(halted),      32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
